sprite_plot_arbiter: RTL and testbench
======================================

Name: sprite_plot_arbiter

Overview:
Shares the single VGA adapter write port and the sprite ROM between the user-control and enemy-control FSMs. Each FSM raises a draw request with a sprite select and base position. The arbiter grants one requester at a time, round-robin on ties, and streams that sprite pixel-by-pixel into the VGA adapter. It then pulses a per-requester done, which the FSMs use to leave their DRAW states.

Parameters:
SPRITE_W, 16, sprite width in pixels (power of 2)
SPRITE_H, 32, sprite height in pixels (power of 2)
SEL_W, 2, sprite select width (up to 4 sprites in ROM)
X_W, 8, VGA x coordinate width
Y_W, 7, VGA y coordinate width
COLOUR_W, 3, pixel colour width
(derived localparam) ROM_AW = SEL_W + log2(SPRITE_W*SPRITE_H)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
user_req  in  1  user draw request, level, held until user_done
user_x  in  X_W  user sprite base x
user_y  in  Y_W  user sprite base y
user_sel  in  SEL_W  user sprite index
user_done  out  1  one-cycle pulse, user sprite fully plotted
enemy_req  in  1  enemy draw request, same rules as user_req
enemy_x  in  X_W  enemy sprite base x
enemy_y  in  Y_W  enemy sprite base y
enemy_sel  in  SEL_W  enemy sprite index
enemy_done  out  1  one-cycle pulse, enemy sprite fully plotted
rom_addr  out  ROM_AW  sprite ROM address
rom_data  in  COLOUR_W  ROM pixel, valid one cycle after rom_addr
vga_x  out  X_W  pixel x to VGA adapter
vga_y  out  Y_W  pixel y to VGA adapter
vga_colour  out  COLOUR_W  pixel colour
vga_plot  out  1  write strobe to VGA adapter
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-low; clock clock): state=IDLE, cx=cy=0, all outputs 0, last_grant=ENEMY (user wins the first tie).
- Applying reset mid-draw aborts the draw. No done pulse is issued; the partially drawn sprite is left on screen.
- States:
  - IDLE: requests are sampled only here. One requester high -> grant it. Both high -> grant the one that is not last_grant. Next state GRANT.
  - GRANT (1 cycle): latch base x/y/sel of the winner, set last_grant, clear cx, cy. Next state DRAW.
  - DRAW: each cycle rom_addr = sel*W*H + cy*W + cx (row-major). cx increments; on cx=W-1, cx wraps to 0 and cy increments. After issuing cx=W-1, cy=H-1 -> FLUSH.
  - FLUSH (1 cycle): the last pixel is plotted. Next state DONE.
  - DONE (1 cycle): pulse the granted requester's done. Next state IDLE.
- Pixel pipeline, 1 stage:
  - cx/cy are delayed one cycle alongside the ROM read.
  - In the cycle after an address issue: vga_plot=1, vga_x=(base_x+cx_d) mod 2^X_W, vga_y=(base_y+cy_d) mod 2^Y_W, vga_colour=rom_data.
  - No clipping; coordinates wrap.
- Latency, with the request sampled at cycle 0: first plot at cycle 3, last plot at cycle W*H+2, done at cycle W*H+3. Default total is 516 cycles.
- Requester rules:
  - req must stay high until done.
  - The requester drops req on the edge where it sees done. req still high in the following IDLE cycle counts as a new request.
  - Changing x/y/sel after GRANT has no effect on the draw in progress.
  - A request arriving while busy waits in IDLE; no request is lost while req is held.
- vga_plot is 0 in IDLE, GRANT and DONE, and in the first DRAW cycle.

Optional Feature:
SPRITE_TRANSPARENT_EN
- Defined: a pixel whose rom_data == 0 gets vga_plot=0 for that cycle (background shows through). x/y/colour still update; timing is unchanged.
- Undefined: every pixel is plotted, including colour 0.

Decomposition:
- Package punchout_pkg:
  - arbiter state encoding (IDLE, GRANT, DRAW, FLUSH, DONE)
  - requester IDs (REQ_USER=0, REQ_ENEMY=1)
  - default sprite dimensions
  - colour width
- Sub-module sprite_addr_counter: cx/cy counters with clear, enable, row-wrap and last-pixel flag.

Test Plan:
- Single user request: user_req=1, x=10, y=20, sel=1 at cycle 0 -> rom_addr=512 at cycle 2. First plot at cycle 3 with (10,20). Last plot at cycle 514 with (25,51). user_done=1 at cycle 515 only.
- Tie after reset: both req high at cycle 0 -> user granted. Both re-request immediately -> enemy granted next. Exactly 512 plots per grant.
- Enemy requests while user busy: enemy_req at cycle 100 -> no enemy plot before user_done. Enemy GRANT in the cycle after returning to IDLE.
- Wrap: enemy x=250, y=0 -> vga_x goes 250..255, then 0..9 on each row.
- Reset at cycle 200 of a draw -> vga_plot=0 and busy=0 the next cycle, no done pulse. A fresh request then restarts from cx=cy=0.
- SPRITE_TRANSPARENT_EN defined with ROM row 0 all zeros -> no vga_plot for cy=0 pixels. Done is still at cycle 515.

Source files
------------

// File: rtl/sprite_plot_arbiter_pkg.sv
// Shared types and defaults for the sprite plot arbiter slice.
// SPRITE_TRANSPARENT_EN (optional) is consumed by the top module, not here.
package punchout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_DRAW  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  typedef enum logic {
    REQ_USER  = 1'b0,
    REQ_ENEMY = 1'b1
  } req_id_t;

  localparam int SPRITE_W_DEF = 16;
  localparam int SPRITE_H_DEF = 32;
  localparam int COLOUR_W_DEF = 3;

endpackage

// File: rtl/sprite_plot_arbiter_if.sv
// Requester, sprite ROM and VGA write-port signals of the sprite plot arbiter.
// master = environment (FSMs, ROM, adapter); slave = arbiter.
interface sprite_plot_arbiter_if
  import punchout_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int SEL_W    = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = COLOUR_W_DEF
);
  localparam int ROM_AW = SEL_W + $clog2(SPRITE_W * SPRITE_H);

  logic                user_req;
  logic [X_W-1:0]      user_x;
  logic [Y_W-1:0]      user_y;
  logic [SEL_W-1:0]    user_sel;
  logic                user_done;
  logic                enemy_req;
  logic [X_W-1:0]      enemy_x;
  logic [Y_W-1:0]      enemy_y;
  logic [SEL_W-1:0]    enemy_sel;
  logic                enemy_done;
  logic [ROM_AW-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                busy;

  modport master (
    output user_req, user_x, user_y, user_sel,
    output enemy_req, enemy_x, enemy_y, enemy_sel,
    output rom_data,
    input  user_done, enemy_done, rom_addr,
    input  vga_x, vga_y, vga_colour, vga_plot, busy
  );

  modport slave (
    input  user_req, user_x, user_y, user_sel,
    input  enemy_req, enemy_x, enemy_y, enemy_sel,
    input  rom_data,
    output user_done, enemy_done, rom_addr,
    output vga_x, vga_y, vga_colour, vga_plot, busy
  );

endinterface

// File: rtl/sprite_plot_arbiter_addr_counter.sv
// Row-major pixel counter for one sprite: cx runs 0..W-1, then cy advances.
// o_last flags the final pixel (cx=W-1, cy=H-1) of the sprite.
module sprite_addr_counter
  import punchout_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  localparam int CX_W = $clog2(SPRITE_W),
  localparam int CY_W = $clog2(SPRITE_H)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [CX_W-1:0] o_cx,
  output logic [CY_W-1:0] o_cy,
  output logic            o_last
);
  localparam logic [CX_W-1:0] CX_MAX = CX_W'(SPRITE_W - 1);
  localparam logic [CY_W-1:0] CY_MAX = CY_W'(SPRITE_H - 1);

  logic [CX_W-1:0] r_cx;
  logic [CY_W-1:0] r_cy;

  // cy wraps naturally because the height is a power of two
  always_ff @(posedge clock) begin
    if (!reset_n || i_clr) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_en) begin
      if (r_cx == CX_MAX) begin
        r_cx <= '0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

  assign o_cx   = r_cx;
  assign o_cy   = r_cy;
  assign o_last = (r_cx == CX_MAX) && (r_cy == CY_MAX);

endmodule

// File: rtl/sprite_plot_arbiter.sv
// Round-robin arbiter streaming one ROM sprite at a time into the VGA write port.
// Optional macro SPRITE_TRANSPARENT_EN: colour-0 pixels are not plotted.
module sprite_plot_arbiter
  import punchout_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int SEL_W    = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = COLOUR_W_DEF
) (
  input logic                  clock,
  input logic                  reset_n,
  sprite_plot_arbiter_if.slave bus
);
  localparam int CX_W = $clog2(SPRITE_W);
  localparam int CY_W = $clog2(SPRITE_H);

  arb_state_t       r_state;
  req_id_t          r_grant;
  req_id_t          r_last_grant;
  req_id_t          w_win;
  logic [X_W-1:0]   r_base_x;
  logic [Y_W-1:0]   r_base_y;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;
  logic             r_user_done;
  logic             r_enemy_done;

  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_last;
  logic [CX_W-1:0]  w_cx;
  logic [CY_W-1:0]  w_cy;

  logic             r_vld_p1;
  logic [X_W-1:0]   r_x_p1;
  logic [Y_W-1:0]   r_y_p1;

  // On a tie the requester that was not served last wins
  always_comb begin
    w_win = REQ_ENEMY;
    if (bus.user_req && bus.enemy_req)
      w_win = (r_last_grant == REQ_ENEMY) ? REQ_USER : REQ_ENEMY;
    else if (bus.user_req)
      w_win = REQ_USER;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= REQ_USER;
      r_last_grant <= REQ_ENEMY;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_sel        <= '0;
      r_busy       <= 1'b0;
      r_user_done  <= 1'b0;
      r_enemy_done <= 1'b0;
    end else begin
      r_user_done  <= 1'b0;
      r_enemy_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.user_req || bus.enemy_req) begin
            r_grant <= w_win;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (r_grant == REQ_USER) begin
            r_base_x <= bus.user_x;
            r_base_y <= bus.user_y;
            r_sel    <= bus.user_sel;
          end else begin
            r_base_x <= bus.enemy_x;
            r_base_y <= bus.enemy_y;
            r_sel    <= bus.enemy_sel;
          end
          r_last_grant <= r_grant;
          r_state      <= ST_DRAW;
        end
        ST_DRAW: begin
          if (w_last) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_user_done  <= (r_grant == REQ_USER);
          r_enemy_done <= (r_grant == REQ_ENEMY);
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_cnt_clr = (r_state == ST_GRANT);
  assign w_cnt_en  = (r_state == ST_DRAW);

  sprite_addr_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_addr_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_cx    (w_cx),
    .o_cy    (w_cy),
    .o_last  (w_last)
  );

  // Stage p0 -> p1: coordinates travel alongside the synchronous ROM read
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_vld_p1 <= 1'b0;
      r_x_p1   <= '0;
      r_y_p1   <= '0;
    end else begin
      r_vld_p1 <= (r_state == ST_DRAW);
      r_x_p1   <= r_base_x + X_W'(w_cx);
      r_y_p1   <= r_base_y + Y_W'(w_cy);
    end
  end

  assign bus.rom_addr   = {r_sel, w_cy, w_cx};
  assign bus.vga_x      = r_x_p1;
  assign bus.vga_y      = r_y_p1;
  assign bus.vga_colour = r_vld_p1 ? bus.rom_data : '0;
`ifdef SPRITE_TRANSPARENT_EN
  assign bus.vga_plot   = r_vld_p1 && (bus.rom_data != '0);
`else
  assign bus.vga_plot   = r_vld_p1;
`endif
  assign bus.busy       = r_busy;
  assign bus.user_done  = r_user_done;
  assign bus.enemy_done = r_enemy_done;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Bench for sprite_plot_arbiter: table of draw requests plus hand-written reset abort,
// with a pixel scoreboard filled when requests are driven. Honours SPRITE_TRANSPARENT_EN.
module tb_sprite_plot_arbiter;

  typedef logic [17:0] pix_t;

  typedef struct {
    logic       ureq;
    logic       ereq;
    logic [7:0] ux;
    logic [6:0] uy;
    logic [1:0] us;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [1:0] es;
    int         e_delay;
    logic       first_e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   u_done_cnt;
  int   e_done_cnt;
  pix_t sb[$];
  vec_t vecs[6];

  sprite_plot_arbiter_if bus ();

  sprite_plot_arbiter dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sprite ROM model: row 0 of every sprite is colour 0
  function automatic logic [2:0] rom_fn(input logic [10:0] a);
    int v;
    if (a[8:4] == 5'd0) return 3'd0;
    v = int'(a[3:0]) + 3 * int'(a[8:4]) + 5 * int'(a[10:9]);
    return v[2:0];
  endfunction

  always @(posedge clk) begin
    bus.rom_data <= rom_fn(bus.rom_addr);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_sprite(input logic [7:0] x, input logic [6:0] y, input logic [1:0] sel);
    logic [2:0]  c;
    logic [10:0] a;
    for (int py = 0; py < 32; py++) begin
      for (int px = 0; px < 16; px++) begin
        a = {sel, 5'(py), 4'(px)};
        c = rom_fn(a);
`ifdef SPRITE_TRANSPARENT_EN
        if (c == 3'd0) continue;
`endif
        sb.push_back({8'(int'(x) + px), 7'(int'(y) + py), c});
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.user_done)  u_done_cnt <= u_done_cnt + 1;
    if (bus.enemy_done) e_done_cnt <= e_done_cnt + 1;
    if (bus.vga_plot) begin
      if (sb.size() == 0) begin
        chk("unexpected_plot", 1, 0);
      end else begin
        chk("pixel_xyc", {bus.vga_x, bus.vga_y, bus.vga_colour}, sb.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int k, n, u0, e0, exp_u, exp_e;
    logic u_seen, e_seen;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [1:0] fs;
    @(negedge clk);
    k  = cyc;
    u0 = u_done_cnt;
    e0 = e_done_cnt;
    bus.user_x  = v.ux; bus.user_y  = v.uy; bus.user_sel  = v.us;
    bus.enemy_x = v.ex; bus.enemy_y = v.ey; bus.enemy_sel = v.es;
    bus.user_req  = v.ureq;
    bus.enemy_req = v.ereq && (v.e_delay == 0);
    fx = v.first_e ? v.ex : v.ux;
    fy = v.first_e ? v.ey : v.uy;
    fs = v.first_e ? v.es : v.us;
    push_sprite(fx, fy, fs);
    if (v.first_e && v.ureq) push_sprite(v.ux, v.uy, v.us);
    if (!v.first_e && v.ereq && v.e_delay == 0) push_sprite(v.ex, v.ey, v.es);
    exp_u = (v.first_e && v.ereq) ? k + 1031 : k + 515;
    exp_e = (!v.first_e && v.ureq) ? k + 1031 : k + 515;
    u_seen = !v.ureq;
    e_seen = !v.ereq;
    n = 0;
    while (!(u_seen && e_seen) && n < 1200) begin
      @(negedge clk);
      n++;
      if (cyc == k + 1) chk("busy_in_grant", bus.busy, 1);
      if (cyc == k + 2) begin
        chk("rom_addr_first", bus.rom_addr, int'(fs) * 512);
        chk("no_plot_first_draw", bus.vga_plot, 0);
        if (v.first_e) begin
          bus.enemy_x = 8'($urandom); bus.enemy_y = 7'($urandom); bus.enemy_sel = 2'($urandom);
        end else begin
          bus.user_x = 8'($urandom); bus.user_y = 7'($urandom); bus.user_sel = 2'($urandom);
        end
      end
      if (cyc == k + 3) begin
`ifdef SPRITE_TRANSPARENT_EN
        chk("row0_transparent", bus.vga_plot, 0);
`else
        chk("first_plot_xy", {bus.vga_plot, bus.vga_x, bus.vga_y}, {1'b1, fx, fy});
`endif
      end
      if (v.e_delay > 0 && cyc == k + v.e_delay) begin
        bus.enemy_req = 1'b1;
        push_sprite(v.ex, v.ey, v.es);
      end
      if (bus.user_done && !u_seen) begin
        chk("user_done_cycle", cyc, exp_u);
        u_seen = 1'b1;
        bus.user_req = 1'b0;
      end
      if (bus.enemy_done && !e_seen) begin
        chk("enemy_done_cycle", cyc, exp_e);
        e_seen = 1'b1;
        bus.enemy_req = 1'b0;
      end
    end
    if (!u_seen) chk("user_done_timeout", 0, 1);
    if (!e_seen) chk("enemy_done_timeout", 0, 1);
    bus.user_req  = 1'b0;
    bus.enemy_req = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {bus.busy, bus.vga_plot, bus.user_done, bus.enemy_done}, 0);
    chk("user_done_pulses", u_done_cnt - u0, int'(v.ureq));
    chk("enemy_done_pulses", e_done_cnt - e0, int'(v.ereq));
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    vec_t tie;
    int   k, u0;
    n_checks = 0; n_fail = 0; cyc = 0;
    u_done_cnt = 0; e_done_cnt = 0;
    rst_n = 1'b0;
    bus.user_req = 1'b0;  bus.user_x = '0;  bus.user_y = '0;  bus.user_sel = '0;
    bus.enemy_req = 1'b0; bus.enemy_x = '0; bus.enemy_y = '0; bus.enemy_sel = '0;

    //          ureq  ereq  ux     uy     us    ex      ey     es    dly  first_e
    vecs[0] = '{1'b1, 1'b1, 8'd10, 7'd20, 2'd1, 8'd250, 7'd0,  2'd2, 0,   1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'd10, 7'd20, 2'd1, 8'd0,   7'd0,  2'd0, 0,   1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'd3, 7'd100, 2'd0, 8'd40,  7'd60, 2'd3, 0,   1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'd0,  7'd0,  2'd0, 8'd250, 7'd0,  2'd2, 0,   1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'd0,  7'd0,  2'd0, 8'd30,  7'd40, 2'd3, 100, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'd255, 7'd127, 2'd3, 8'd0, 7'd0,  2'd0, 0,   1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {bus.busy, bus.vga_plot, bus.user_done, bus.enemy_done, bus.vga_x, bus.vga_y, bus.vga_colour},
        0);
    chk("reset_rom_addr", bus.rom_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", bus.busy, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort a user draw with reset partway through
    @(negedge clk);
    k  = cyc;
    u0 = u_done_cnt;
    bus.user_x = 8'd10; bus.user_y = 7'd20; bus.user_sel = 2'd1;
    bus.user_req = 1'b1;
    push_sprite(8'd10, 7'd20, 2'd1);
    while (cyc < k + 200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_plot_busy", {bus.vga_plot, bus.busy, bus.user_done}, 0);
    chk("abort_rom_addr", bus.rom_addr, 0);
    rst_n = 1'b1;
    bus.user_req = 1'b0;
    sb.delete();
    repeat (600) @(negedge clk);
    chk("abort_no_done", u_done_cnt - u0, 0);
    chk("abort_stays_idle", bus.busy, 0);

    // After reset the user again wins a tie and restarts from pixel 0
    tie = '{1'b1, 1'b1, 8'd7, 7'd9, 2'd2, 8'd100, 7'd50, 2'd1, 0, 1'b0};
    run_vec(tie);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
